// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sequencer sharing one dual-port RAM between
// two requesters, with a hardware clear sweep. At most one RAM operation is
// issued per cycle so the RAM's write-over-read priority never hides a request.
module ram_port_arbiter #(
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,

    output logic [DW-1:0] rdata,

    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,

    output logic          ram_wr,
    output logic          ram_re,
    output logic [AW-1:0] ram_wr_addr,
    output logic [AW-1:0] ram_re_addr,
    output logic [DW-1:0] ram_d_in,
    input  logic [DW-1:0] ram_d_out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic          last_b;      // 1: B was granted most recently
    logic          a_rd_tag;    // A read in flight on the RAM read port
    logic          b_rd_tag;    // B read in flight on the RAM read port
    logic [DW-1:0] rdata_q;     // last delivered read data

    logic          a_elig_c;
    logic          b_elig_c;
    logic          pick_a_c;
    logic          pick_b_c;

    // Eligibility and round-robin pick; a requester whose grant is showing now sits out one cycle
    always_comb begin
        a_elig_c = a_req & ~a_gnt;
        b_elig_c = b_req & ~b_gnt;
        pick_a_c = a_elig_c & (~b_elig_c | last_b);
        pick_b_c = b_elig_c & ~pick_a_c;
    end

    // The RAM read port is already registered: pass its output through while a
    // read returns, otherwise present the held copy of the last returned data.
    assign rdata = (a_rvalid | b_rvalid) ? ram_d_out : rdata_q;

    // Sequencer: state, grants, RAM command and read-return pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            a_rd_tag    <= 1'b0;
            b_rd_tag    <= 1'b0;
            rdata_q     <= '0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            busy        <= 1'b0;
            clr_done    <= 1'b0;
            ram_wr      <= 1'b0;
            ram_re      <= 1'b0;
            ram_wr_addr <= '0;
            ram_re_addr <= '0;
            ram_d_in    <= '0;
        end else begin
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            ram_wr   <= 1'b0;
            ram_re   <= 1'b0;
            clr_done <= 1'b0;
            a_rd_tag <= 1'b0;
            b_rd_tag <= 1'b0;
            // read return runs independently of the state so a read issued
            // just before a sweep still completes
            a_rvalid <= a_rd_tag;
            b_rvalid <= b_rd_tag;
            if (a_rvalid | b_rvalid) begin
                rdata_q <= ram_d_out;
            end

            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        ram_wr      <= 1'b1;
                        ram_wr_addr <= '0;
                        ram_d_in    <= '0;
                    end else if (pick_a_c) begin
                        a_gnt  <= 1'b1;
                        last_b <= 1'b0;
                        if (a_we) begin
                            ram_wr      <= 1'b1;
                            ram_wr_addr <= a_addr;
                            ram_d_in    <= a_wdata;
                        end else begin
                            ram_re      <= 1'b1;
                            ram_re_addr <= a_addr;
                            a_rd_tag    <= 1'b1;
                        end
                    end else if (pick_b_c) begin
                        b_gnt  <= 1'b1;
                        last_b <= 1'b1;
                        if (b_we) begin
                            ram_wr      <= 1'b1;
                            ram_wr_addr <= b_addr;
                            ram_d_in    <= b_wdata;
                        end else begin
                            ram_re      <= 1'b1;
                            ram_re_addr <= b_addr;
                            b_rd_tag    <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    if (ram_wr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        ram_wr      <= 1'b1;
                        ram_wr_addr <= ram_wr_addr + AW'(1);
                        ram_d_in    <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic against a
// schedule-based model of grants, RAM commands, read returns and clear sweeps.
module tb_ram_port_arbiter;

    localparam int MAXC = 8192;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [3:0] a_addr = '0;
    logic [7:0] a_wdata = '0;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [3:0] b_addr = '0;
    logic [7:0] b_wdata = '0;
    logic       clr_req = 1'b0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, busy, clr_done;
    logic       ram_wr, ram_re;
    logic [3:0] ram_wr_addr, ram_re_addr;
    logic [7:0] ram_d_in, rdata;
    logic [7:0] ram_d_out = '0;

    ram_port_arbiter #(.AW(4), .DW(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid),
        .rdata(rdata), .clr_req(clr_req), .busy(busy), .clr_done(clr_done),
        .ram_wr(ram_wr), .ram_re(ram_re), .ram_wr_addr(ram_wr_addr),
        .ram_re_addr(ram_re_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
    );

    always #5 clk = ~clk;

    // 16x8 RAM: write port plus registered read port, no reset
    logic [7:0] tb_mem [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_wr) tb_mem[ram_wr_addr] <= ram_d_in;
        if (ram_re) ram_d_out <= tb_mem[ram_re_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -1000;
        return q[i];
    endfunction

    // Requester command queues; the driver advances a pointer on each grant
    cmd_t a_q[$];
    cmd_t b_q[$];
    int   a_ptr = 0;
    int   b_ptr = 0;

    task automatic push_a(input bit we, input int addr, input int data);
        a_q.push_back(cmd_t'{we, 4'(addr), 8'(data)});
    endtask
    task automatic push_b(input bit we, input int addr, input int data);
        b_q.push_back(cmd_t'{we, 4'(addr), 8'(data)});
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) a_ptr = a_q.size();
        else if (a_gnt && a_ptr < a_q.size()) a_ptr++;
        if (rst && a_ptr < a_q.size()) begin
            a_req = 1'b1; a_we = a_q[a_ptr].we; a_addr = a_q[a_ptr].addr; a_wdata = a_q[a_ptr].data;
        end else begin
            a_req = 1'b0; a_we = 1'($urandom_range(0, 1));
            a_addr = 4'($urandom_range(0, 15)); a_wdata = 8'($urandom_range(0, 255));
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) b_ptr = b_q.size();
        else if (b_gnt && b_ptr < b_q.size()) b_ptr++;
        if (rst && b_ptr < b_q.size()) begin
            b_req = 1'b1; b_we = b_q[b_ptr].we; b_addr = b_q[b_ptr].addr; b_wdata = b_q[b_ptr].data;
        end else begin
            b_req = 1'b0; b_we = 1'($urandom_range(0, 1));
            b_addr = 4'($urandom_range(0, 15)); b_wdata = 8'($urandom_range(0, 255));
        end
    end

    // Model schedule: what each output must show in cycle k
    bit         e_agnt [MAXC];
    bit         e_bgnt [MAXC];
    bit         e_arv  [MAXC];
    bit         e_brv  [MAXC];
    bit         e_wr   [MAXC];
    bit         e_re   [MAXC];
    bit         e_busy [MAXC];
    bit         e_done [MAXC];
    logic [3:0] e_wa   [MAXC];
    logic [3:0] e_ra   [MAXC];
    logic [7:0] e_din  [MAXC];
    int         idle_from = 0;
    bit         m_last_b = 1'b1;

    // Model decisions at each rising edge from the sampled requests
    always @(posedge clk) begin : model_dec
        int cur;
        bit ea, eb, ga, gb;
        cur = cyc;
        if (cur + 20 >= MAXC) begin
            $display("FAIL schedule_overflow actual=%0d required<%0d", cur, MAXC - 20);
            $fatal(1, "schedule overflow");
        end
        if (!rst) begin
            for (int i = cur; i < MAXC; i++) begin
                e_agnt[i] = 0; e_bgnt[i] = 0; e_arv[i] = 0; e_brv[i] = 0;
                e_wr[i] = 0; e_re[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            end
            idle_from = 0;
            m_last_b = 1'b1;
        end else if (cur >= idle_from) begin
            if (clr_req) begin
                for (int i = 0; i < 16; i++) begin
                    e_wr[cur+1+i] = 1; e_wa[cur+1+i] = 4'(i); e_din[cur+1+i] = 8'h00;
                    e_busy[cur+1+i] = 1;
                end
                e_done[cur+17] = 1;
                idle_from = cur + 17;
            end else begin
                ea = a_req && !e_agnt[cur];
                eb = b_req && !e_bgnt[cur];
                ga = (ea && eb) ? m_last_b : ea;
                gb = eb && !ga;
                if (ga) begin
                    e_agnt[cur+1] = 1; m_last_b = 1'b0;
                    if (a_we) begin e_wr[cur+1] = 1; e_wa[cur+1] = a_addr; e_din[cur+1] = a_wdata; end
                    else begin e_re[cur+1] = 1; e_ra[cur+1] = a_addr; e_arv[cur+2] = 1; end
                end else if (gb) begin
                    e_bgnt[cur+1] = 1; m_last_b = 1'b1;
                    if (b_we) begin e_wr[cur+1] = 1; e_wa[cur+1] = b_addr; e_din[cur+1] = b_wdata; end
                    else begin e_re[cur+1] = 1; e_ra[cur+1] = b_addr; e_brv[cur+2] = 1; end
                end
            end
        end
        cyc = cur + 1;
    end

    // Logs for directed checks
    int order[$];
    int a_gcyc[$], b_gcyc[$];
    int a_rd[$], a_rcyc[$], b_rd[$];
    int clr_addr[$], done_cyc[$];
    int busy_cnt = 0;

    logic [7:0] mmem [16] = '{default: 8'h00};
    logic [7:0] rd_next = '0;
    logic [7:0] hold = '0;

    // Compare DUT outputs to the model mid-cycle
    always @(negedge clk) begin : cmp
        int c;
        c = cyc;
        if (!rst) begin
            chk("rst_a_gnt", a_gnt, 0);     chk("rst_b_gnt", b_gnt, 0);
            chk("rst_a_rvalid", a_rvalid, 0); chk("rst_b_rvalid", b_rvalid, 0);
            chk("rst_busy", busy, 0);       chk("rst_clr_done", clr_done, 0);
            chk("rst_ram_wr", ram_wr, 0);   chk("rst_ram_re", ram_re, 0);
            chk("rst_rdata", rdata, 0);
            hold = '0;
        end else begin
            if (e_arv[c] || e_brv[c]) hold = rd_next;
            chk("a_gnt", a_gnt, e_agnt[c]);
            chk("b_gnt", b_gnt, e_bgnt[c]);
            chk("a_rvalid", a_rvalid, e_arv[c]);
            chk("b_rvalid", b_rvalid, e_brv[c]);
            chk("rdata", rdata, hold);
            chk("ram_wr", ram_wr, e_wr[c]);
            chk("ram_re", ram_re, e_re[c]);
            chk("wr_re_excl", ram_wr & ram_re, 0);
            chk("busy", busy, e_busy[c]);
            chk("clr_done", clr_done, e_done[c]);
            if (e_wr[c]) begin
                chk("ram_wr_addr", ram_wr_addr, e_wa[c]);
                chk("ram_d_in", ram_d_in, e_din[c]);
            end
            if (e_re[c]) begin
                chk("ram_re_addr", ram_re_addr, e_ra[c]);
                rd_next = mmem[e_ra[c]];
            end
            if (e_wr[c]) mmem[e_wa[c]] = e_din[c];

            if (a_gnt) begin order.push_back(0); a_gcyc.push_back(c); end
            if (b_gnt) begin order.push_back(1); b_gcyc.push_back(c); end
            if (a_rvalid) begin a_rd.push_back(int'(rdata)); a_rcyc.push_back(c); end
            if (b_rvalid) b_rd.push_back(int'(rdata));
            if (busy) begin
                busy_cnt++;
                if (ram_wr) clr_addr.push_back(int'(ram_wr_addr));
            end
            if (clr_done) done_cyc.push_back(c);
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (a_ptr == a_q.size() && b_ptr == b_q.size() && !busy && !clr_req) begin
                ok = 1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        chk("idle_reached", ok, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ob, bb, ab, ar, bc, nd, na, ag, br;
        rst = 1'b0;
        clr_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // A writes 0x11 @7 while B reads @7: first tie after reset goes to A
        ob = order.size(); bb = b_rd.size();
        push_a(1, 7, 'h11);
        push_b(0, 7, 0);
        wait_idle();
        chk("t4_first_gnt_a", qget(order, ob), 0);
        chk("t4_second_gnt_b", qget(order, ob + 1), 1);
        chk("t4_b_rdata", qget(b_rd, bb), 'h11);

        // A writes 0x5A @3 then reads it back
        ab = a_gcyc.size(); ar = a_rd.size();
        push_a(1, 3, 'h5A);
        push_a(0, 3, 0);
        wait_idle();
        chk("t2_gnt_spacing", qget(a_gcyc, ab + 1) - qget(a_gcyc, ab), 2);
        chk("t2_rdata", qget(a_rd, ar), 'h5A);
        chk("t2_rvalid_after_gnt", qget(a_rcyc, ar) - qget(a_gcyc, ab + 1), 1);

        // Both requesting continuously: last grant was A, so B,A,B,A,...
        ob = order.size();
        for (int i = 0; i < 6; i++) begin
            push_a($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
            push_b($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        wait_idle();
        for (int i = 0; i < 12; i++)
            chk("t3_alternate", qget(order, ob + i), (i % 2 == 0) ? 1 : 0);

        // Fill with 0xFF, sweep, A request waits during the sweep
        for (int i = 0; i < 16; i++) push_a(1, i, 'hFF);
        wait_idle();
        bc = busy_cnt; nd = done_cyc.size(); na = clr_addr.size();
        ag = a_gcyc.size(); ar = a_rd.size();
        clr_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy) break;
        end
        clr_req = 1'b0;
        push_a(0, 5, 0);
        wait_idle();
        chk("t5_busy_cycles", busy_cnt - bc, 16);
        chk("t5_done_pulses", done_cyc.size() - nd, 1);
        for (int i = 0; i < 16; i++) chk("t5_clr_addr", qget(clr_addr, na + i), i);
        chk("t6_gnt_after_done", qget(a_gcyc, ag) - qget(done_cyc, nd), 1);
        chk("t6_rdata_zero", qget(a_rd, ar), 0);
        br = b_rd.size();
        for (int i = 0; i < 16; i++) push_b(0, i, 0);
        wait_idle();
        for (int i = 0; i < 16; i++) chk("t5_read_zero", qget(b_rd, br + i), 0);

        // Random traffic with occasional clear pulses
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0 && a_q.size() - a_ptr < 3)
                push_a($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0 && b_q.size() - b_ptr < 3)
                push_b($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
            clr_req = ($urandom_range(0, 99) == 0);
        end
        clr_req = 1'b0;
        wait_idle();

        // Reset in the middle of traffic
        for (int i = 0; i < 8; i++) begin
            push_a($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
            push_b($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t1_async_gnt", {a_gnt, b_gnt}, 0);
        chk("t1_async_ram", {ram_wr, ram_re}, 0);
        chk("t1_async_misc", {a_rvalid, b_rvalid, busy, clr_done}, 0);
        chk("t1_async_bus", {ram_wr_addr, ram_re_addr, ram_d_in, rdata}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        ob = order.size();
        push_a(0, 1, 0);
        push_b(0, 2, 0);
        wait_idle();
        chk("t1_first_tie_a", qget(order, ob), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
